// File: rtl/ram_access_ctrl_if.sv
// Single RAM request port between the coherence controller (master) and
// the main-memory controller (slave), with the four-value ramstate handshake.
interface ram_access_ctrl_if;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Word-addressed main memory with fixed access latency and a FREE/BUSY/ACCESS/ERROR handshake.
// Optional feature: RAM_BOUNDS_CHECK_EN turns out-of-range byte addresses into ERROR.
module ram_access_ctrl #(
    parameter int LAT   = 2,
    parameter int DEPTH = 16384
) (
    input  logic              CLK,
    input  logic              nRST,
    ram_access_ctrl_if.slave  bus
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [3:0] LAT4 = 4'(LAT);

    // State encoding doubles as the ramstate code, so ramstate comes straight off a flop.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACC  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [29:0] lat_addr, lat_addr_n;
    logic        lat_wr, lat_wr_n;
    logic [31:0] load;
    logic [31:0] mem [DEPTH];

    logic req, both, none, changed, oob;
    logic unused_bits;

    assign req     = bus.ramREN ^ bus.ramWEN;
    assign both    = bus.ramREN & bus.ramWEN;
    assign none    = ~bus.ramREN & ~bus.ramWEN;
    assign changed = (bus.ramaddr[31:2] != lat_addr) || (bus.ramWEN != lat_wr);

`ifdef RAM_BOUNDS_CHECK_EN
    assign oob = |bus.ramaddr[31:AW+2];
`else
    assign oob = 1'b0;
`endif
    assign unused_bits = ^bus.ramaddr[1:0];

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lat_addr_n = lat_addr;
        lat_wr_n   = lat_wr;
        unique case (state)
            IDLE: begin
                if (both) begin
                    state_n = ERR;
                end else if (req) begin
                    lat_addr_n = bus.ramaddr[31:2];
                    lat_wr_n   = bus.ramWEN;
                    cnt_n      = LAT4;
                    if (oob)           state_n = ERR;
                    else if (LAT == 0) state_n = ACC;
                    else               state_n = WAIT;
                end
            end
            WAIT: begin
                if (none) begin
                    state_n = IDLE;
                end else if (both) begin
                    state_n = ERR;
                end else if (changed) begin
                    // Requester moved to a new address/op: restart the full latency.
                    lat_addr_n = bus.ramaddr[31:2];
                    lat_wr_n   = bus.ramWEN;
                    cnt_n      = LAT4;
                    state_n    = oob ? ERR : WAIT;
                end else begin
                    cnt_n = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                    if (cnt <= 4'd1) state_n = ACC;
                end
            end
            ACC:     state_n = IDLE;
            ERR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
            load     <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lat_addr <= lat_addr_n;
            lat_wr   <= lat_wr_n;
            if (state_n == ACC && !lat_wr_n)
                load <= mem[lat_addr_n[AW-1:0]];
        end
    end

    // Write commits on the edge leaving ACCESS; a reset forces state out of ACC first.
    always_ff @(posedge CLK) begin
        if (state == ACC && lat_wr && bus.ramWEN)
            mem[lat_addr[AW-1:0]] <= bus.ramstore;
    end

    assign bus.ramload  = load;
    assign bus.ramstate = state;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized bench for ram_access_ctrl: three instances (LAT 2, 0, 3) checked against a word-array model.
`timescale 1ns/1ps
module tb_ram_access_ctrl;
    localparam int DEPTH = 16384;
    localparam int NW    = 16;
`ifdef RAM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif
    localparam logic [1:0] S_FREE = 2'd0, S_BUSY = 2'd1, S_ACC = 2'd2, S_ERR = 2'd3;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic              ren   [3];
    logic              wen   [3];
    logic [31:0]       addr  [3];
    logic [31:0]       store [3];
    logic [2:0][31:0]  load;
    logic [2:0][1:0]   st;

    int          lat_of [3] = '{2, 0, 3};
    logic [31:0] model [3][NW];
    logic [31:0] exp_load [3];
    int          n_chk  = 0;
    int          n_fail = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ram_access_ctrl_if bus ();
        assign bus.ramREN   = ren[g];
        assign bus.ramWEN   = wen[g];
        assign bus.ramaddr  = addr[g];
        assign bus.ramstore = store[g];
        assign load[g]      = bus.ramload;
        assign st[g]        = bus.ramstate;
        ram_access_ctrl #(.LAT(g == 0 ? 2 : (g == 1 ? 0 : 3)), .DEPTH(DEPTH)) u_dut (
            .CLK  (CLK),
            .nRST (nRST),
            .bus  (bus.slave)
        );
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drop(int i);
        ren[i] = 1'b0;
        wen[i] = 1'b0;
    endtask

    // Waits out BUSY, checks latency/state/data, then drops the request one cycle later.
    task automatic finish_txn(int i, int exp_n, logic [1:0] exp_st, string tag);
        int n = 0;
        int w = int'(addr[i][5:2]);
        do begin
            tick();
            n++;
        end while (st[i] == S_BUSY && n < 40);
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_state"}, 32'(st[i]), 32'(exp_st));
        if (exp_st == S_ACC && !wen[i]) begin
            exp_load[i] = model[i][w];
            chk({tag, "_rdata"}, load[i], exp_load[i]);
        end else if (exp_st == S_ERR) begin
            chk({tag, "_load_kept"}, load[i], exp_load[i]);
        end
        tick();
        if (exp_st == S_ACC && wen[i]) model[i][w] = store[i];
        drop(i);
        chk({tag, "_free"}, 32'(st[i]), 32'(S_FREE));
    endtask

    task automatic txn(int i, logic r, logic w, logic [31:0] a, logic [31:0] d, string tag);
        logic bad;
        ren[i] = r; wen[i] = w; addr[i] = a; store[i] = d;
        bad = (r && w) || (BC && (a[31:16] != 16'h0));
        finish_txn(i, bad ? 1 : lat_of[i] + 1, bad ? S_ERR : S_ACC, tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            drop(i);
            addr[i] = '0;
            store[i] = '0;
            exp_load[i] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_state%0d", i), 32'(st[i]), 32'(S_FREE));
            chk($sformatf("rst_load%0d", i), load[i], 32'h0);
        end
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // Directed first write/read on the LAT=2 instance.
        txn(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, "w40");
        txn(0, 1'b1, 1'b0, 32'h40, 32'h0, "r40");
        chk("r40_value", load[0], 32'hDEADBEEF);

        // Give every word of the test window a known value.
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < NW; w++)
                txn(i, 1'b0, 1'b1, 32'(w * 4), $urandom, $sformatf("init%0d_%0d", i, w));

        // LAT=0 back-to-back reads.
        txn(1, 1'b1, 1'b0, 32'h0, 32'h0, "l0_r0");
        txn(1, 1'b1, 1'b0, 32'h4, 32'h0, "l0_r4");

        // Mid-wait address switch on LAT=3.
        ren[2] = 1'b1; wen[2] = 1'b0; addr[2] = 32'h10;
        tick(); chk("mw_busy1", 32'(st[2]), 32'(S_BUSY));
        tick(); chk("mw_busy2", 32'(st[2]), 32'(S_BUSY));
        addr[2] = 32'h20;
        finish_txn(2, 4, S_ACC, "mw");

        // Write dropped while BUSY must not land.
        for (int i = 0; i < 3; i += 2) begin
            ren[i] = 1'b0; wen[i] = 1'b1; addr[i] = 32'h8; store[i] = 32'h1234;
            tick(); chk($sformatf("dropw%0d_busy", i), 32'(st[i]), 32'(S_BUSY));
            drop(i);
            tick(); chk($sformatf("dropw%0d_free", i), 32'(st[i]), 32'(S_FREE));
            txn(i, 1'b1, 1'b0, 32'h8, 32'h0, $sformatf("dropw%0d_rd", i));
        end

        // Simultaneous read+write is an error; follow with a read to confirm memory untouched.
        for (int i = 0; i < 3; i++) begin
            txn(i, 1'b1, 1'b1, 32'h14, 32'hFFFF0000, $sformatf("err%0d", i));
            txn(i, 1'b1, 1'b0, 32'h14, 32'h0, $sformatf("err%0d_rd", i));
        end

        // Out-of-range byte address: ERROR with the bounds check, alias of word 0 without.
        txn(0, 1'b1, 1'b0, 32'h10000, 32'h0, "bounds");

        // Reset pulsed during BUSY of a write.
        ren[0] = 1'b0; wen[0] = 1'b1; addr[0] = 32'hC; store[0] = 32'hA5A5A5A5;
        tick(); chk("rstw_busy", 32'(st[0]), 32'(S_BUSY));
        #2 nRST = 1'b0;
        #1;
        chk("rstw_state", 32'(st[0]), 32'(S_FREE));
        chk("rstw_load", load[0], 32'h0);
        for (int i = 0; i < 3; i++) exp_load[i] = '0;
        drop(0);
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        txn(0, 1'b1, 1'b0, 32'hC, 32'h0, "rstw_rd");

        // Randomized traffic.
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < 3; i++) begin
                int op = $urandom_range(0, 9);
                logic [31:0] a;
                a = {15'h0, 1'($urandom_range(0, 7) == 0), 10'h0, 4'($urandom_range(0, NW - 1)), 2'($urandom)};
                if (op == 0)      txn(i, 1'b1, 1'b1, a, $urandom, $sformatf("rnd%0d_%0d_err", it, i));
                else if (op < 5)  txn(i, 1'b0, 1'b1, a, $urandom, $sformatf("rnd%0d_%0d_wr", it, i));
                else              txn(i, 1'b1, 1'b0, a, 32'h0, $sformatf("rnd%0d_%0d_rd", it, i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

- Word-addressed main-memory controller sitting directly downstream of the coherence controller.
- Consumes its single RAM request port (ramREN/ramWEN/ramaddr/ramstore) and reports progress through the shared four-value ramstate handshake.
- Models a fixed access latency, commits writes, returns read data, and flags malformed requests.
- The coherence controller holds a request stable until it sees ACCESS. This block guarantees ACCESS appears for exactly one cycle per accepted request.

## Interface
Parameters:
- LAT, 2, number of BUSY cycles between request acceptance and ACCESS (0..15).
- DEPTH, 16384, memory depth in 32-bit words (power of two).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ramREN  in  1  read request.
- ramWEN  in  1  write request.
- ramaddr  in  32  byte address; bits [1:0] ignored.
- ramstore  in  32  write data.
- ramload  out  32  read data, registered.
- ramstate  out  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3; registered.

## Operation
- Memory index is ramaddr[log2(DEPTH)+1:2].
- States and transitions:
  - IDLE (ramstate FREE):
    - ramREN&ramWEN → ERR.
    - Otherwise, one request present → latch addr/op, load counter with LAT → WAIT. If LAT=0, go → ACC instead.
    - No request → stay IDLE.
  - WAIT (BUSY):
    - Request dropped → IDLE. Nothing is written.
    - ramaddr or op differs from the latch → re-latch, reload counter with LAT, stay in WAIT.
    - Otherwise decrement the counter; at 1 → ACC.
  - ACC (ACCESS), always exactly one cycle, then → IDLE.
    - Read: ramload was loaded from mem[latched index] on the entering edge and is held until the next read.
    - Write: mem[latched index] ← ramstore, sampled on the edge leaving ACC, only if ramWEN is still asserted then.
  - ERR (ERROR), one cycle, then → IDLE. No memory update; ramload unchanged.
- A request still asserted after ACCESS is treated as a new request from IDLE. The requester must drop or change it; this block does not suppress it.
- Counter is 4 bits; it never wraps below 0.

## Timing
- Reset: ramstate=FREE, ramload=0, counter=0, latch cleared. Memory contents are not reset.
- Reset asserted mid-operation aborts the access immediately. No write occurs. FREE holds from the reset edge.
- A request first seen in cycle k gives:
  - BUSY in cycles k+1..k+LAT.
  - ACCESS in cycle k+LAT+1.
  - FREE in cycle k+LAT+2.
- Minimum request-to-request spacing is LAT+2 cycles.
- Read data is valid on ramload throughout the ACCESS cycle and afterwards until the next read.
- A write is visible to a read whose ACCESS occurs at least one cycle later.

## Configuration
- RAM_BOUNDS_CHECK_EN defined:
  - On acceptance in IDLE (or re-latch in WAIT), a byte address ≥ 4*DEPTH → ERR instead of WAIT/ACC.
  - Nothing is written and ramload is unchanged.
- Undefined:
  - Upper address bits are ignored and addresses wrap modulo DEPTH words.
  - ERROR arises only from simultaneous ramREN/ramWEN.

## Test plan
- Reset, LAT=2:
  - Stimulus: ramWEN=1, addr 0x40, data 0xDEADBEEF in cycle 0.
  - Required: BUSY in cycles 1-2, ACCESS in cycle 3, FREE in cycle 4.
  - Then ramREN to 0x40 → ramload=0xDEADBEEF during its ACCESS cycle.
- LAT=0:
  - Stimulus: back-to-back reads of 0x0 and 0x4, each dropped one cycle after ACCESS.
  - Required: ACCESS one cycle after each request, separated by a FREE cycle.
- Mid-wait change, LAT=3:
  - Stimulus: read 0x10, switched to 0x20 in the second BUSY cycle.
  - Required: counter reloads, ACCESS 4 cycles after the switch, data = mem[0x20].
- Request dropped during BUSY:
  - Stimulus: write to 0x8 (value 0x1234) dropped while BUSY.
  - Required: FREE next cycle; a subsequent read of 0x8 returns the old value.
- ramREN=ramWEN=1:
  - Required: ERROR for one cycle, then FREE; memory and ramload unchanged.
- Bounds and reset:
  - With RAM_BOUNDS_CHECK_EN, read of 0x10000 (DEPTH=16384) → ERROR.
  - Without the macro, the same read returns mem[0x0].
  - nRST pulsed during BUSY of a write to 0xC → FREE, ramload=0, no write.
